debug_unit: RTL

- UART-side controller placed directly upstream of the pipeline top. It drives every pipeline debug input: clock enable, PC reset, instruction-memory write, debug address and instruction data.
- It decodes host command bytes to load a program, reset the PC, run to halt or single-step.
- After each run or step it streams the register file and a data-memory window back to the host, byte by byte.
- Connects to an external uart_rx / uart_tx pair through byte-level handshakes.

---
 rtl/debug_pkg.sv | 30 +++
 rtl/dbg_word_tx.sv | 53 +++++
 rtl/debug_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the UART debug controller: sizes, command/status codes, FSM states.
// Ports: none (package).
// Imported by debug_unit and dbg_word_tx.
package debug_pkg;

    localparam int NB_REG         = 32;   // data/address word width
    localparam int NB_BYTE        = 8;    // UART byte width
    localparam int NB_RADDR       = 5;    // register index width
    localparam int N_REGS         = 32;   // registers dumped
    localparam int MEM_DUMP_WORDS = 32;   // data-memory words dumped
    localparam int IMEM_WORDS     = 128;  // instruction-memory capacity in words

    localparam logic [NB_REG-1:0]  HALT_WORD = 32'hFFFF_FFFF;

    localparam logic [NB_BYTE-1:0] CMD_LOAD  = 8'h4C;  // 'L'
    localparam logic [NB_BYTE-1:0] CMD_RESET = 8'h52;  // 'R'
    localparam logic [NB_BYTE-1:0] CMD_CONT  = 8'h43;  // 'C'
    localparam logic [NB_BYTE-1:0] CMD_STEP  = 8'h53;  // 'S'
    localparam logic [NB_BYTE-1:0] ST_HALT   = 8'h48;  // 'H'
    localparam logic [NB_BYTE-1:0] ST_OK     = 8'h4B;  // 'K'

    typedef enum logic [3:0] {
        IDLE, LOAD_BYTE, LOAD_WRITE, RST_PC, RUN, STEP,
        DUMP_STATUS, DUMP_ADDR, DUMP_LATCH, DUMP_SEND, DUMP_WAIT
    } state_t;

    // Which section of the dump stream is being sent.
    typedef enum logic [1:0] {PH_STATUS, PH_REGS, PH_MEM} phase_t;

endpackage

// File: rtl/dbg_word_tx.sv
// Serialises up to 4 bytes of a word MSB first over a start/done byte handshake; done pulses after the last byte.
// Ports: clk, rst_n, start/word/nbytes (request), tx_data/tx_start/tx_done (UART side), done (word finished).
// Latency: first byte one cycle after start, each next byte one cycle after tx_done; start is ignored while busy.
module dbg_word_tx
    import debug_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NB_REG-1:0]  word,
    input  logic [2:0]         nbytes,
    input  logic               tx_done,
    output logic [NB_BYTE-1:0] tx_data,
    output logic               tx_start,
    output logic               done
);

    logic [NB_REG-1:0] shreg;
    logic [2:0]        left;   // bytes still to send after the one in flight
    logic              busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            left     <= '0;
            busy     <= 1'b0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            if (start && !busy) begin
                tx_data  <= word[NB_REG-1 -: NB_BYTE];
                tx_start <= 1'b1;
                shreg    <= word << NB_BYTE;
                left     <= nbytes - 3'd1;
                busy     <= 1'b1;
            end else if (busy && tx_done) begin
                if (left == 3'd0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    tx_data  <= shreg[NB_REG-1 -: NB_BYTE];
                    tx_start <= 1'b1;
                    shreg    <= shreg << NB_BYTE;
                    left     <= left - 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/debug_unit.sv
// UART debug controller: loads instruction memory, resets PC, runs/steps the pipeline, then dumps regs and data memory.
// Ports: i_clk/i_reset, UART rx/tx byte handshakes, pipeline debug inputs (clk_en, reset_pc, w_mem, addr, data_if), halt/reg/mem readback.
// Latency: writes one cycle after the 4th load byte; dump bytes wait for i_tx_done each; rx bytes outside IDLE/LOAD are dropped.
module debug_unit
    import debug_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    input  logic [NB_REG-1:0]  i_dunit_reg,
    input  logic [NB_REG-1:0]  i_dunit_mem_data,
    input  logic               i_halt,
    output logic               o_dunit_clk_en,
    output logic               o_dunit_reset_pc,
    output logic               o_dunit_w_mem,
    output logic [NB_REG-1:0]  o_dunit_addr,
    output logic [NB_REG-1:0]  o_dunit_data_if
);

    localparam int WIDX_W   = $clog2(IMEM_WORDS) + 1;
    localparam int DUMP_MAX = (N_REGS > MEM_DUMP_WORDS) ? N_REGS : MEM_DUMP_WORDS;
    localparam int DIDX_W   = $clog2(DUMP_MAX);

    state_t             state, state_nxt;
    phase_t             phase;
    logic [DIDX_W-1:0]  didx;
    logic [WIDX_W-1:0]  widx;
    logic [1:0]         bcnt;
    logic [23:0]        shreg;    // first three bytes of the word being loaded
    logic [NB_REG-1:0]  cap;
    logic               tx_go;
    logic [NB_REG-1:0]  tx_word;
    logic [2:0]         tx_n;
    logic               word_done;
    logic               dump_last;

    assign dump_last = (phase == PH_MEM) && (didx == DIDX_W'(MEM_DUMP_WORDS - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD:  state_nxt = LOAD_BYTE;
                        CMD_RESET: state_nxt = RST_PC;
                        CMD_CONT:  state_nxt = RUN;
                        CMD_STEP:  state_nxt = STEP;
                        default:   state_nxt = IDLE;
                    endcase
                end
            end
            LOAD_BYTE:   if (i_rx_done && bcnt == 2'd3) state_nxt = LOAD_WRITE;
            LOAD_WRITE:  state_nxt = (o_dunit_data_if == HALT_WORD ||
                                      widx == WIDX_W'(IMEM_WORDS - 1)) ? IDLE : LOAD_BYTE;
            RST_PC:      state_nxt = IDLE;
            RUN:         if (i_halt) state_nxt = DUMP_STATUS;
            STEP:        state_nxt = DUMP_STATUS;
            DUMP_STATUS: state_nxt = DUMP_WAIT;
            DUMP_ADDR:   state_nxt = DUMP_LATCH;
            DUMP_LATCH:  state_nxt = DUMP_SEND;
            DUMP_SEND:   state_nxt = DUMP_WAIT;
            DUMP_WAIT:   if (word_done) state_nxt = dump_last ? IDLE : DUMP_ADDR;
            default:     state_nxt = IDLE;
        endcase
    end

    // clk_en is combinational so the pipeline freezes in the very cycle halt rises.
    always_comb begin
        o_dunit_clk_en = (state == RUN || state == STEP) && !i_halt;
        tx_go          = (state == DUMP_STATUS) || (state == DUMP_SEND);
        tx_word        = cap;
        tx_n           = 3'd4;
        if (state == DUMP_STATUS) begin
            tx_word = {(i_halt ? ST_HALT : ST_OK), 24'h0};
            tx_n    = 3'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            phase            <= PH_STATUS;
            didx             <= '0;
            widx             <= '0;
            bcnt             <= '0;
            shreg            <= '0;
            cap              <= '0;
            o_dunit_reset_pc <= 1'b0;
            o_dunit_w_mem    <= 1'b0;
            o_dunit_addr     <= '0;
            o_dunit_data_if  <= '0;
        end else begin
            o_dunit_reset_pc <= 1'b0;
            o_dunit_w_mem    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rx_done && i_rx_data == CMD_LOAD) begin
                        widx <= '0;
                        bcnt <= '0;
                    end
                    if (i_rx_done && i_rx_data == CMD_RESET) o_dunit_reset_pc <= 1'b1;
                end
                LOAD_BYTE: begin
                    if (i_rx_done) begin
                        shreg <= {shreg[15:0], i_rx_data};
                        bcnt  <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            o_dunit_w_mem   <= 1'b1;
                            o_dunit_data_if <= {shreg, i_rx_data};
                            o_dunit_addr    <= NB_REG'({widx[WIDX_W-2:0], 2'b00});
                        end
                    end
                end
                LOAD_WRITE: widx <= widx + 1'b1;
                DUMP_ADDR: begin
                    if (phase == PH_REGS) o_dunit_addr <= NB_REG'(didx[NB_RADDR-1:0]);
                    else                  o_dunit_addr <= NB_REG'({didx, 2'b00});
                end
                // Readback is combinational from o_dunit_addr, which settled last cycle.
                DUMP_LATCH: cap <= (phase == PH_REGS) ? i_dunit_reg : i_dunit_mem_data;
                DUMP_WAIT: begin
                    if (word_done) begin
                        case (phase)
                            PH_STATUS: begin
                                phase <= PH_REGS;
                                didx  <= '0;
                            end
                            PH_REGS: begin
                                if (didx == DIDX_W'(N_REGS - 1)) begin
                                    phase <= PH_MEM;
                                    didx  <= '0;
                                end else begin
                                    didx <= didx + 1'b1;
                                end
                            end
                            default: begin
                                if (dump_last) begin
                                    phase <= PH_STATUS;
                                    didx  <= '0;
                                end else begin
                                    didx <= didx + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    dbg_word_tx u_word_tx (
        .clk      (i_clk),
        .rst_n    (i_reset),
        .start    (tx_go),
        .word     (tx_word),
        .nbytes   (tx_n),
        .tx_done  (i_tx_done),
        .tx_data  (o_tx_data),
        .tx_start (o_tx_start),
        .done     (word_done)
    );

endmodule
